// File: rtl/alu_seq.sv
// Handshaked sequential ALU for the ez8 core: one operation in flight, registered results.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for opcode 12.
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             skip,
    output logic             illegal
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_ANDN = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;
    localparam logic [3:0] OP_SKEQ = 4'd13;
    localparam logic [3:0] OP_SKNE = 4'd14;
    localparam logic [3:0] OP_SKLT = 4'd15;

    localparam logic [SHIFT_W:0] CNT_ONE = (SHIFT_W+1)'(1);
    localparam logic [SHIFT_W:0] CNT_MUL = (SHIFT_W+1)'(WIDTH);

    logic [1:0]       state_r;
    logic [SHIFT_W:0] cnt_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_hi_r;
    logic             carry_r;
    logic             zero_r;
    logic             skip_r;
    logic             illegal_r;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] work_hi_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH:0]   mul_sum_s;
`endif

    logic             accept_s;
    logic [WIDTH-1:0] b_op_s;
    logic             cin_op_s;
    logic [WIDTH:0]   sum_s;
    logic             go_busy_s;
    logic [WIDTH-1:0] one_res_s;
    logic             one_carry_s;
    logic             one_skip_s;
    logic             one_illegal_s;
    logic [WIDTH-1:0] step_work_s;
    logic [WIDTH-1:0] step_hi_s;
    logic             step_carry_s;
    logic [SHIFT_W-1:0] shamt_s;

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign shamt_s   = b[SHIFT_W-1:0];
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign skip      = skip_r;
    assign illegal   = illegal_r;

    // Operand conditioning for the shared WIDTH+1 bit adder
    always_comb begin
        b_op_s   = b;
        cin_op_s = 1'b0;
        case (op)
            OP_SUB:  begin b_op_s = ~b; cin_op_s = 1'b1; end
            OP_ADDC: begin b_op_s = b;  cin_op_s = cin;  end
            OP_SUBC: begin b_op_s = ~b; cin_op_s = cin;  end
            default: begin b_op_s = b;  cin_op_s = 1'b0; end
        endcase
        sum_s = {1'b0, a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_op_s};
    end

    // Single-cycle results and the decision to enter the iterative path
    always_comb begin
        one_res_s     = a;
        one_carry_s   = 1'b0;
        one_skip_s    = 1'b0;
        one_illegal_s = 1'b0;
        go_busy_s     = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADDC, OP_SUBC: begin
                one_res_s   = sum_s[WIDTH-1:0];
                one_carry_s = sum_s[WIDTH];
            end
            OP_AND:  one_res_s = a & b;
            OP_OR:   one_res_s = a | b;
            OP_XOR:  one_res_s = a ^ b;
            OP_ANDN: one_res_s = a & ~b;
            OP_SHL, OP_SHR, OP_SRA, OP_ROL: go_busy_s = (shamt_s != '0);
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  go_busy_s = 1'b1;
`else
            OP_MUL: begin
                one_res_s     = '0;
                one_illegal_s = 1'b1;
            end
`endif
            OP_SKEQ: one_skip_s = (a == b);
            OP_SKNE: one_skip_s = (a != b);
            OP_SKLT: one_skip_s = (a < b);
            default: one_res_s = a;
        endcase
    end

    // One iteration of the held shift/rotate or shift-add multiply
    always_comb begin
        step_work_s  = work_r;
        step_hi_s    = '0;
        step_carry_s = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_sum_s    = {1'b0, work_hi_r} + (work_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
`endif
        case (op_r)
            OP_SHL: begin
                step_work_s  = {work_r[WIDTH-2:0], 1'b0};
                step_carry_s = work_r[WIDTH-1];
            end
            OP_SHR: begin
                step_work_s  = {1'b0, work_r[WIDTH-1:1]};
                step_carry_s = work_r[0];
            end
            OP_SRA: begin
                step_work_s  = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
                step_carry_s = work_r[0];
            end
            OP_ROL: begin
                step_work_s  = {work_r[WIDTH-2:0], work_r[WIDTH-1]};
                step_carry_s = work_r[WIDTH-1];
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                step_work_s = {mul_sum_s[0], work_r[WIDTH-1:1]};
                step_hi_s   = mul_sum_s[WIDTH:1];
            end
`endif
            default: step_work_s = work_r;
        endcase
    end

    // Control FSM, iteration registers and the registered result bank
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= 4'd0;
            work_r      <= '0;
            result_r    <= '0;
            result_hi_r <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            skip_r      <= 1'b0;
            illegal_r   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            work_hi_r   <= '0;
            mcand_r     <= '0;
`endif
        end else if (accept_s) begin
            op_r <= op;
            if (go_busy_s) begin
                state_r <= ST_BUSY;
                work_r  <= a;
                cnt_r   <= (op == OP_MUL) ? CNT_MUL : {1'b0, shamt_s};
`ifdef ALU_SEQ_MUL_EN
                work_hi_r <= '0;
                mcand_r   <= b;
`endif
            end else begin
                state_r     <= ST_DONE;
                result_r    <= one_res_s;
                result_hi_r <= '0;
                carry_r     <= one_carry_s;
                zero_r      <= (one_res_s == '0);
                skip_r      <= one_skip_s;
                illegal_r   <= one_illegal_s;
            end
        end else begin
            case (state_r)
                ST_BUSY: begin
                    work_r <= step_work_s;
                    cnt_r  <= cnt_r - CNT_ONE;
`ifdef ALU_SEQ_MUL_EN
                    work_hi_r <= step_hi_s;
`endif
                    if (cnt_r == CNT_ONE) begin
                        state_r     <= ST_DONE;
                        result_r    <= step_work_s;
                        result_hi_r <= step_hi_s;
                        carry_r     <= step_carry_s;
                        zero_r      <= (step_work_s == '0);
                        skip_r      <= 1'b0;
                        illegal_r   <= 1'b0;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: state_r <= out_ready ? ST_IDLE : ST_DONE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=8); follows ALU_SEQ_MUL_EN for opcode 12 expectations.
module tb_alu_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       carry;
    logic       zero;
    logic       skip;
    logic       illegal;

    int chk_cnt;
    int pass_cnt;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .carry(carry), .zero(zero),
        .skip(skip), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present one op at the falling edge; returns just after the accepting rising edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb, input logic vc);
        @(negedge clk);
        op = o; a = va; b = vb; cin = vc; in_valid = 1'b1;
        check("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("pop_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [7:0] er, input logic [7:0] eh, input logic ec,
                       input logic es, input logic ei, input int elat);
        issue(o, va, vb, vc);
        wait_valid(tag, elat);
        check({tag, "_res"},   {24'd0, result},    {24'd0, er});
        check({tag, "_hi"},    {24'd0, result_hi}, {24'd0, eh});
        check({tag, "_carry"}, {31'd0, carry},     {31'd0, ec});
        check({tag, "_zero"},  {31'd0, zero},      {31'd0, (er == 8'd0)});
        check({tag, "_skip"},  {31'd0, skip},      {31'd0, es});
        check({tag, "_ill"},   {31'd0, illegal},   {31'd0, ei});
        pop();
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = 8'd0; b = 8'd0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    {24'd0, result},    32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);

        //   tag      op     a      b      cin   res    hi     c     skip  ill   lat
        run("add",   4'd0,  8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        run("sub",   4'd1,  8'h05, 8'h05, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        run("subc",  4'd3,  8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("addc",  4'd2,  8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1);
        run("and",   4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("or",    4'd5,  8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("xor",   4'd6,  8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("andn",  4'd7,  8'hF0, 8'h30, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("shl1",  4'd8,  8'h81, 8'h01, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run("shr2",  4'd9,  8'h81, 8'h02, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 3);
        run("sra3",  4'd10, 8'h81, 8'h03, 1'b0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 4);
        run("rol1",  4'd11, 8'h81, 8'h01, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run("shl0",  4'd8,  8'h5A, 8'h08, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        run("skeq",  4'd13, 8'h03, 8'h03, 1'b0, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        run("skne",  4'd14, 8'h03, 8'h03, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1);
`ifdef ALU_SEQ_MUL_EN
        run("mul",   4'd12, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 9);
`else
        run("mul",   4'd12, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1);
`endif

        // Back-pressure: hold a SKLT result while an ignored request is presented.
        issue(4'd15, 8'h03, 8'h07, 1'b0);
        wait_valid("sklt", 1);
        op = 4'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_valid",    {31'd0, out_valid}, 32'd1);
            check("hold_result",   {24'd0, result},    32'h03);
            check("hold_skip",     {31'd0, skip},      32'd1);
            check("hold_in_ready", {31'd0, in_ready},  32'd0);
            @(posedge clk); #1;
        end
        op = 4'd0; a = 8'h10; b = 8'h22; out_ready = 1'b1;
        #1 check("pulse_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid",  {31'd0, out_valid}, 32'd1);
        check("b2b_result", {24'd0, result},    32'h32);
        check("b2b_skip",   {31'd0, skip},      32'd0);
        pop();

        // Reset in the middle of a long shift discards it.
        issue(4'd8, 8'hFF, 8'h07, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", {24'd0, result},    32'd0);
        check("mid_rst_flags",  {28'd0, carry, zero, skip, illegal}, 32'd0);
        check("mid_rst_hi",     {24'd0, result_hi}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1 check("discarded_valid", {31'd0, out_valid}, 32'd0);
        run("post_add", 4'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
